fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, IDLE/RUN/HALT control FSM
// and the IF/ID pipeline register feeding decode.
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned D_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic [D_WIDTH-1:0]    instr,
    output logic [D_WIDTH-1:0]    if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic [ADDR_WIDTH-1:0] if_id_pc_next,
    output logic                  if_id_valid,
    output logic [1:0]            fetch_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [D_WIDTH-1:0]    instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc_next;
        logic                  valid;
    } if_id_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    if_id_t                ifid_q;
    if_id_t                ifid_d;

    // One-hot RUN action: halt beats redirect beats stall.
    logic act_halt;
    logic act_redir;
    logic act_stall;
    logic act_fetch;

    assign act_halt  = halt;
    assign act_redir = !halt && redirect;
    assign act_stall = !halt && !redirect && stall;
    assign act_fetch = !halt && !redirect && !stall;

    // Natural wrap at all-ones comes from the fixed width.
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    // Next-state, next-PC and next IF/ID slot.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        unique case (state_q)
            IDLE, HALT: begin
                ifid_d.valid = 1'b0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                unique case (1'b1)
                    act_halt: begin
                        state_d      = HALT;
                        ifid_d.valid = 1'b0;
                    end
                    act_redir: begin
                        pc_d         = redirect_pc;
                        ifid_d.valid = 1'b0;
                    end
                    act_stall: begin
                        pc_d = pc_q;
                    end
                    act_fetch: begin
                        ifid_d = '{
                            instr:   instr,
                            pc:      pc_q,
                            pc_next: pc_inc,
                            valid:   1'b1
                        };
                        pc_d = pc_inc;
                    end
                    default: begin
                        pc_d = pc_q;
                    end
                endcase
            end
            default: begin
                state_d      = IDLE;
                ifid_d.valid = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign pc_addr       = pc_q;
    assign if_id_instr   = ifid_q.instr;
    assign if_id_pc      = ifid_q.pc;
    assign if_id_pc_next = ifid_q.pc_next;
    assign if_id_valid   = ifid_q.valid;
    assign fetch_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner sequences
// and randomized run against a behavioural model.
module tb_fetch_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        start, halt, stall, redirect;
    logic [31:0] rpc;
    logic [31:0] pc_addr, instr;
    logic [31:0] ii, ipc, inext;
    logic        valid;
    logic [1:0]  state;

    logic        w_start, w_zero;
    logic [31:0] w_rpc;
    logic [31:0] w_pc, w_instr;
    logic [31:0] w_ii, w_ipc, w_inext;
    logic        w_valid;
    logic [1:0]  w_state;

    logic [31:0] mem [256];

    int nerr = 0;
    int nchk = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .halt(halt),
        .stall(stall), .redirect(redirect),
        .redirect_pc(rpc), .pc_addr(pc_addr),
        .instr(instr), .if_id_instr(ii),
        .if_id_pc(ipc), .if_id_pc_next(inext),
        .if_id_valid(valid), .fetch_state(state)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .start(w_start), .halt(w_zero),
        .stall(w_zero), .redirect(w_zero),
        .redirect_pc(w_rpc), .pc_addr(w_pc),
        .instr(w_instr), .if_id_instr(w_ii),
        .if_id_pc(w_ipc), .if_id_pc_next(w_inext),
        .if_id_valid(w_valid), .fetch_state(w_state)
    );

    assign instr   = mem[pc_addr[7:0]];
    assign w_instr = mem[w_pc[7:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        s, h, st, rd;
        logic [31:0] rpc;
        logic [1:0]  fs;
        logic [31:0] pc;
        logic        v;
        logic [31:0] ipc, inext, ins;
    } vec_t;

    vec_t tv[20];

    function automatic logic [31:0] mv(input logic [31:0] a);
        return 32'hA000_0000 + {24'h0, a[7:0]};
    endfunction

    function automatic vec_t mk(
        input logic s, h, st, rd,
        input logic [31:0] r,
        input logic [1:0] fs,
        input logic [31:0] pc,
        input logic v,
        input logic [31:0] ip, nx, ins
    );
        vec_t t;
        t.s = s; t.h = h; t.st = st; t.rd = rd;
        t.rpc = r; t.fs = fs; t.pc = pc; t.v = v;
        t.ipc = ip; t.inext = nx; t.ins = ins;
        return t;
    endfunction

    task automatic chk(
        input string name,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " state"}, 64'(state), 64'(0));
        chk({tag, " pc"}, 64'(pc_addr), 64'(0));
        chk({tag, " instr"}, 64'(ii), 64'(0));
        chk({tag, " ipc"}, 64'(ipc), 64'(0));
        chk({tag, " inext"}, 64'(inext), 64'(0));
        chk({tag, " valid"}, 64'(valid), 64'(0));
    endtask

    // Behavioural reference: state 0=idle 1=run 2=halt.
    int          m_st;
    logic [31:0] m_pc, m_ii, m_ipc, m_nx;
    logic        m_v;

    task automatic m_reset();
        m_st = 0; m_pc = 0; m_ii = 0;
        m_ipc = 0; m_nx = 0; m_v = 0;
    endtask

    task automatic m_step();
        if (m_st != 1) begin
            if (start) m_st = 1;
        end else if (halt) begin
            m_st = 2;
            m_v = 0;
        end else if (redirect) begin
            m_pc = rpc;
            m_v = 0;
        end else if (!stall) begin
            m_ii = mem[m_pc[7:0]];
            m_ipc = m_pc;
            m_nx = m_pc + 1;
            m_v = 1;
            m_pc = m_pc + 1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = mv(32'(i));
        rst_n = 0; start = 0; halt = 0;
        stall = 0; redirect = 0; rpc = 0;
        w_start = 0; w_zero = 0; w_rpc = 0;

        // Reset and idle hold.
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1;
        tick();
        tick();
        chk("idle_hold state", 64'(state), 64'(0));
        chk("idle_hold pc", 64'(pc_addr), 64'(0));

        tv[0]  = mk(H,L,L,L, 0, 1, 0, L, 0, 0, 0);
        tv[1]  = mk(L,L,L,L, 0, 1, 1, H, 0, 1, mv(0));
        tv[2]  = mk(L,L,L,L, 0, 1, 2, H, 1, 2, mv(1));
        tv[3]  = mk(L,L,L,L, 0, 1, 3, H, 2, 3, mv(2));
        tv[4]  = mk(L,L,L,L, 0, 1, 4, H, 3, 4, mv(3));
        tv[5]  = mk(L,L,L,L, 0, 1, 5, H, 4, 5, mv(4));
        tv[6]  = mk(L,L,H,L, 0, 1, 5, H, 4, 5, mv(4));
        tv[7]  = mk(L,L,H,L, 0, 1, 5, H, 4, 5, mv(4));
        tv[8]  = mk(L,L,H,L, 0, 1, 5, H, 4, 5, mv(4));
        tv[9]  = mk(L,L,L,L, 0, 1, 6, H, 5, 6, mv(5));
        tv[10] = mk(L,L,L,L, 0, 1, 7, H, 6, 7, mv(6));
        tv[11] = mk(L,L,H,H, 32'h40, 1, 32'h40, L,
                    6, 7, mv(6));
        tv[12] = mk(L,L,L,L, 0, 1, 32'h41, H,
                    32'h40, 32'h41, mv(32'h40));
        tv[13] = mk(L,L,L,H, 9, 1, 9, L,
                    32'h40, 32'h41, mv(32'h40));
        tv[14] = mk(L,H,L,H, 32'h33, 2, 9, L,
                    32'h40, 32'h41, mv(32'h40));
        tv[15] = mk(L,L,H,H, 32'h22, 2, 9, L,
                    32'h40, 32'h41, mv(32'h40));
        tv[16] = mk(L,H,L,L, 0, 2, 9, L,
                    32'h40, 32'h41, mv(32'h40));
        tv[17] = mk(H,H,L,L, 0, 1, 9, L,
                    32'h40, 32'h41, mv(32'h40));
        tv[18] = mk(L,L,L,L, 0, 1, 10, H, 9, 10, mv(9));
        tv[19] = mk(H,L,L,L, 0, 1, 11, H, 10, 11, mv(10));

        for (int i = 0; i < 20; i++) begin
            start = tv[i].s; halt = tv[i].h;
            stall = tv[i].st; redirect = tv[i].rd;
            rpc = tv[i].rpc;
            tick();
            chk($sformatf("v%0d state", i),
                64'(state), 64'(tv[i].fs));
            chk($sformatf("v%0d pc", i),
                64'(pc_addr), 64'(tv[i].pc));
            chk($sformatf("v%0d valid", i),
                64'(valid), 64'(tv[i].v));
            chk($sformatf("v%0d ipc", i),
                64'(ipc), 64'(tv[i].ipc));
            chk($sformatf("v%0d inext", i),
                64'(inext), 64'(tv[i].inext));
            chk($sformatf("v%0d instr", i),
                64'(ii), 64'(tv[i].ins));
        end
        start = 0; halt = 0; stall = 0;
        redirect = 0; rpc = 0;

        // PC wrap from an all-ones reset vector.
        w_start = 1;
        tick();
        w_start = 0;
        chk("wrap run", 64'(w_state), 64'(1));
        chk("wrap pc0", 64'(w_pc), 64'(32'hFFFF_FFFF));
        tick();
        chk("wrap pc", 64'(w_pc), 64'(0));
        chk("wrap inext", 64'(w_inext), 64'(0));
        chk("wrap ipc", 64'(w_ipc), 64'(32'hFFFF_FFFF));
        chk("wrap valid", 64'(w_valid), 64'(1));
        chk("wrap instr", 64'(w_ii), 64'(mv(32'hFF)));

        // Async reset mid-cycle during stall+redirect.
        stall = 1; redirect = 1; rpc = 32'h55;
        #2;
        rst_n = 0;
        #1;
        chk_reset("async");
        tick();
        rst_n = 1;
        tick();
        tick();
        chk("post_rst state", 64'(state), 64'(0));
        chk("post_rst pc", 64'(pc_addr), 64'(0));
        stall = 0; redirect = 0; rpc = 0;

        // Randomized run against the model.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 7) == 0);
            halt = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFFC + {30'h0, rpc[1:0]};
            if ($urandom_range(0, 255) == 0) begin
                #2;
                rst_n = 0;
                #1;
                chk_reset("rnd_async");
                #1;
                rst_n = 1;
                m_reset();
            end
            m_step();
            tick();
            chk("rnd state", 64'(state), 64'(m_st));
            chk("rnd pc", 64'(pc_addr), 64'(m_pc));
            chk("rnd valid", 64'(valid), 64'(m_v));
            chk("rnd ipc", 64'(ipc), 64'(m_ipc));
            chk("rnd inext", 64'(inext), 64'(m_nx));
            chk("rnd instr", 64'(ii), 64'(m_ii));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
